// File: rtl/lza_leading_zero_counter.sv
// Sequential leading-zero counter for the LZA predicate vector.
// Scans the captured vector MSB-first, GRP bits per cycle, and returns the
// normalisation shift amount through a load/ready/ack handshake.
//
// Optional feature macro: LZD_EARLY_EXIT_EN
//   defined   -> leave SCAN on the edge that finds the first nonzero group
//   undefined -> always scan all NG groups (fixed latency)
// The result is identical in both builds.
//
// SWR must be strictly less than 2**EWR so that a full-zero count fits.

module lza_leading_zero_counter #(
  parameter int unsigned SWR = 26,
  parameter int unsigned EWR = 5,
  parameter int unsigned GRP = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_i,
  input  logic [SWR-1:0] S_i,
  input  logic           ack_i,
  output logic           busy_o,
  output logic           ready_o,
  output logic [EWR-1:0] shift_o,
  output logic           zero_o
);

  localparam int unsigned NG   = (SWR + GRP - 1) / GRP;
  localparam int unsigned PW   = NG * GRP;
  localparam int unsigned KW   = (NG > 1) ? $clog2(NG) : 1;
  // Real (non-padding) bits in the final group.
  localparam int unsigned LastBits = SWR - (NG - 1) * GRP;

  localparam logic [KW-1:0]  LastK       = KW'(NG - 1);
  localparam logic [EWR-1:0] GrpBitsW    = EWR'(GRP);
  localparam logic [EWR-1:0] LastBitsW   = EWR'(LastBits);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e           state_q;
  logic [SWR-1:0]   vec_q;
  logic [EWR-1:0]   count_q;
  logic [KW-1:0]    k_q;
  logic             found_q;
  logic [EWR-1:0]   shift_q;
  logic             zero_q;

  logic [PW-1:0]    padded;
  logic [GRP-1:0]   grp;
  logic             grp_nz;
  logic [EWR-1:0]   grp_lz;
  logic             last_grp;
  logic [EWR-1:0]   count_d;
  logic             found_d;
  logic             scan_exit;

  // Leading zeros of a nonzero group; returns GRP for an all-zero group.
  function automatic logic [EWR-1:0] lzd_grp(input logic [GRP-1:0] g);
    logic [EWR-1:0] n;
    logic           seen;
    n    = '0;
    seen = 1'b0;
    for (int i = GRP - 1; i >= 0; i--) begin
      if (g[i]) begin
        seen = 1'b1;
      end else if (!seen) begin
        n = n + EWR'(1);
      end
    end
    return n;
  endfunction

  // Select group k from the vector, left-aligned with zero padding below bit 0.
  always_comb begin
    padded          = '0;
    padded[PW-1 -: SWR] = vec_q;
    grp             = GRP'(padded >> ((NG - 1 - int'(k_q)) * GRP));
    grp_nz          = |grp;
    grp_lz          = lzd_grp(grp);
    last_grp        = (k_q == LastK);
  end

  // Accumulate the count until the first nonzero group; padding never counts.
  always_comb begin
    count_d = count_q;
    found_d = found_q | grp_nz;
    if (!found_q) begin
      if (grp_nz) begin
        count_d = count_q + grp_lz;
      end else begin
        count_d = count_q + (last_grp ? LastBitsW : GrpBitsW);
      end
    end
  end

  // Decide when SCAN finishes.
  always_comb begin
`ifdef LZD_EARLY_EXIT_EN
    scan_exit = last_grp | found_d;
`else
    scan_exit = last_grp;
`endif
  end

  // Control FSM with captured vector, scan progress and registered result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      vec_q   <= '0;
      count_q <= '0;
      k_q     <= '0;
      found_q <= 1'b0;
      shift_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load_i) begin
            vec_q   <= S_i;
            count_q <= '0;
            k_q     <= '0;
            found_q <= 1'b0;
            state_q <= StScan;
          end
        end
        StScan: begin
          count_q <= count_d;
          found_q <= found_d;
          k_q     <= last_grp ? '0 : k_q + KW'(1);
          if (scan_exit) begin
            shift_q <= count_d;
            zero_q  <= ~found_d;
            state_q <= StDone;
          end
        end
        StDone: begin
          if (ack_i) begin
            if (load_i) begin
              // Back-to-back: capture the next vector without an idle bubble.
              vec_q   <= S_i;
              count_q <= '0;
              k_q     <= '0;
              found_q <= 1'b0;
              state_q <= StScan;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Status decoded straight from the state register.
  always_comb begin
    busy_o  = (state_q == StScan);
    ready_o = (state_q == StDone);
    shift_o = shift_q;
    zero_o  = zero_q;
  end

endmodule

// File: doc/lza_leading_zero_counter.md
Name: lza_leading_zero_counter

Overview:
Sequential leading-zero counter that consumes the SWR-bit LZA predicate vector produced by the LZA combinational logic stage (XNOR of propagate/carry). It scans the captured vector MSB-first, GRP bits per cycle, and returns the normalisation shift amount to the barrel-shifter / exponent-adjust stage. It uses a load/ready/ack handshake so the FPU control FSM can sequence it.

Parameters:
SWR, 26, width of predicate vector S_i (significand working range)
EWR, 5, width of shift_o; must satisfy SWR < 2**EWR
GRP, 4, bits examined per scan cycle; NG = ceil(SWR/GRP) groups

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
load_i  input  1  start request; S_i sampled when accepted
S_i  input  SWR  LZA predicate vector, bit SWR-1 is MSB
ack_i  input  1  consumer acknowledge of result
busy_o  output  1  high in SCAN state
ready_o  output  1  high in DONE state; result valid
shift_o  output  EWR  leading-zero count of captured vector
zero_o  output  1  captured vector was all zeros

Behaviour:
- Reset (rst low, async): state IDLE, busy_o=0, ready_o=0, shift_o=0, zero_o=0, internal vector/group index/found flag cleared. Reset mid-scan aborts; no result produced.
- States: IDLE, SCAN, DONE.
- IDLE: load_i=1 at edge E0 -> capture S_i, count=0, group k=0, found=0, go SCAN. load_i=0 -> stay.
- SCAN: at edge E(k+1) evaluate group k = bits [SWR-1-k*GRP -: GRP]; in the last group, bit positions below 0 are treated as 0.
  - If found=0: count += leading zeros of group (GRP if group all-zero); if group nonzero, set found=1.
  - Exit to DONE after evaluating group NG-1, or earlier per LZD_EARLY_EXIT_EN.
  - load_i and ack_i are ignored in SCAN.
- Exit to DONE registers shift_o=count and zero_o=~found. If all zero: shift_o=SWR (26), zero_o=1.
- DONE: ready_o=1; shift_o/zero_o held stable until ack_i=1.
  - ack_i=1, load_i=0 -> IDLE.
  - ack_i=1, load_i=1 in the same cycle -> capture new S_i, go directly to SCAN (back-to-back, no IDLE bubble).
  - load_i without ack_i -> ignored.
- shift_o and zero_o keep their last value in IDLE and SCAN; they change only on entry to DONE.
- busy_o and ready_o are decoded from the state register and are never high together.
- Arithmetic: count is EWR bits wide and never exceeds SWR, so there is no wrap.

Optional Feature:
Macro LZD_EARLY_EXIT_EN.
- Defined: SCAN goes to DONE at the same edge that finds the first nonzero group. Latency is the number of groups up to and including the first nonzero group (1..NG); all-zero input takes NG.
- Undefined: always scans all NG groups; fixed latency NG (7 for defaults). Groups after the find only advance k. Result is identical either way.

Test Plan:
- Reset: assert rst low mid-SCAN -> busy_o=0, ready_o=0, shift_o=0, zero_o=0 immediately (async); after release, state IDLE.
- S_i=26'h2000000, load at E0 -> shift_o=0, zero_o=0. ready_o high after E1 (early exit) or after E7 (fixed).
- S_i=26'h0040000 -> shift_o=7, zero_o=0. ready after E2 (early) / E7 (fixed).
- S_i=26'h0000001 -> shift_o=25, ready after E7 in both builds, which checks partial last-group padding.
- S_i=0 -> shift_o=26, zero_o=1, ready after E7.
- In DONE: hold ack_i=0 for 5 cycles with load_i pulses -> outputs stable, no new capture. Then ack_i=1 with load_i=1 and S_i=26'h0800000 -> next edge busy_o=1, later shift_o=2.
